// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of one single-port synchronous RAM.
// Every RAM command and ack is registered; read returns are tracked by a tag pipeline.
module ram_port_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqA,
  input  logic              weA,
  input  logic [ADDR_W-1:0] addrA,
  input  logic [DATA_W-1:0] dinA,
  output logic              ackA,
  output logic [DATA_W-1:0] doutA,
  output logic              validA,
  input  logic              reqB,
  input  logic              weB,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [DATA_W-1:0] dinB,
  output logic              ackB,
  output logic [DATA_W-1:0] doutB,
  output logic              validB,
  output logic              ramEn,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramDin,
  input  logic [DATA_W-1:0] ramDout
);

  typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B} state_t;

  state_t              state_q;
  logic                last_grant_b_q;
  logic                ack_a_q, ack_b_q;
  logic                ram_en_q, ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_din_q;
  logic                tag1_valid_q, tag1_port_q;
  logic                tag2_valid_q, tag2_port_q;
  logic [1:0]          valid_q;
  logic [DATA_W-1:0]   dout_q [2];

  logic elig_a, elig_b, grant_a, grant_b, tag1_valid_d;

  // The state register doubles as "ack showing this cycle", so a port is
  // never regranted while its own ack is visible.
  always_comb begin
    elig_a       = reqA && (state_q != SERVE_A);
    elig_b       = reqB && (state_q != SERVE_B);
    grant_a      = elig_a && (!elig_b || last_grant_b_q);
    grant_b      = elig_b && !grant_a;
    tag1_valid_d = (grant_a && !weA) || (grant_b && !weB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_b_q <= 1'b1;
      ack_a_q        <= 1'b0;
      ack_b_q        <= 1'b0;
      ram_en_q       <= 1'b0;
      ram_we_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_din_q      <= '0;
      tag1_valid_q   <= 1'b0;
      tag1_port_q    <= 1'b0;
      tag2_valid_q   <= 1'b0;
      tag2_port_q    <= 1'b0;
    end else begin
      ack_a_q      <= grant_a;
      ack_b_q      <= grant_b;
      tag1_valid_q <= tag1_valid_d;
      tag1_port_q  <= grant_b;
      tag2_valid_q <= tag1_valid_q;
      tag2_port_q  <= tag1_port_q;
      if (grant_a) begin
        state_q        <= SERVE_A;
        last_grant_b_q <= 1'b0;
        ram_en_q       <= 1'b1;
        ram_we_q       <= weA;
        ram_addr_q     <= addrA;
        ram_din_q      <= dinA;
      end else if (grant_b) begin
        state_q        <= SERVE_B;
        last_grant_b_q <= 1'b1;
        ram_en_q       <= 1'b1;
        ram_we_q       <= weB;
        ram_addr_q     <= addrB;
        ram_din_q      <= dinB;
      end else begin
        state_q  <= IDLE;
        ram_en_q <= 1'b0;
        ram_we_q <= 1'b0;
      end
    end
  end

  // Per-port read return: capture RAM data when the oldest tag names this port.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q[gi] <= 1'b0;
          dout_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= tag2_valid_q && (tag2_port_q == 1'(gi));
          if (tag2_valid_q && (tag2_port_q == 1'(gi))) begin
            dout_q[gi] <= ramDout;
          end
        end
      end
    end
  endgenerate

  assign ackA    = ack_a_q;
  assign ackB    = ack_b_q;
  assign ramEn   = ram_en_q;
  assign ramWe   = ram_we_q;
  assign ramAddr = ram_addr_q;
  assign ramDin  = ram_din_q;
  assign validA  = valid_q[0];
  assign validB  = valid_q[1];
  assign doutA   = dout_q[0];
  assign doutB   = dout_q[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM attached.
module tb_ram_port_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              reqA, weA, reqB, weB;
  logic [ADDR_W-1:0] addrA, addrB;
  logic [DATA_W-1:0] dinA, dinB;
  logic              ackA, validA, ackB, validB;
  logic [DATA_W-1:0] doutA, doutB;
  logic              ramEn, ramWe;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramDin, ramDout;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  int n_checks = 0;
  int n_errors = 0;

  ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .reqA(reqA), .weA(weA), .addrA(addrA), .dinA(dinA),
    .ackA(ackA), .doutA(doutA), .validA(validA),
    .reqB(reqB), .weB(weB), .addrB(addrB), .dinB(dinB),
    .ackB(ackB), .doutB(doutB), .validB(validB),
    .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr), .ramDin(ramDin),
    .ramDout(ramDout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramEn) begin
      if (ramWe) mem[ramAddr] <= ramDin;
      else       ramDout <= mem[ramAddr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reqA = 0; weA = 0; addrA = '0; dinA = '0;
    reqB = 0; weB = 0; addrB = '0; dinB = '0;
    tick(); tick();
    check("rst_ackA",  32'(ackA),  0);
    check("rst_ramEn", 32'(ramEn), 0);
    check("rst_doutA", 32'(doutA), 0);
    rst = 0;
    tick();

    // A write 0x5A@0x010 then A read back
    reqA = 1; weA = 1; addrA = 9'h010; dinA = 8'h5A;
    tick();
    check("t2_wr_ackA",    32'(ackA),    1);
    check("t2_wr_ramWe",   32'(ramWe),   1);
    check("t2_wr_ramAddr", 32'(ramAddr), 32'h010);
    check("t2_wr_ramDin",  32'(ramDin),  32'h5A);
    reqA = 0;
    tick();
    check("t2_ack_pulse", 32'(ackA), 0);
    reqA = 1; weA = 0;
    tick();
    check("t2_rd_ackA",  32'(ackA),  1);
    check("t2_rd_ramWe", 32'(ramWe), 0);
    reqA = 0;
    tick();
    check("t2_valid_early", 32'(validA), 0);
    tick();
    check("t2_validA", 32'(validA), 1);
    check("t2_doutA",  32'(doutA),  32'h5A);
    tick();
    check("t2_valid_pulse", 32'(validA), 0);
    check("t2_dout_hold",   32'(doutA),  32'h5A);

    // B writes 0xC3@0x1FF, A reads it in the next slot
    reqB = 1; weB = 1; addrB = 9'h1FF; dinB = 8'hC3;
    tick();
    check("t5_ackB", 32'(ackB), 1);
    check("t5_ackA", 32'(ackA), 0);
    reqB = 0; reqA = 1; weA = 0; addrA = 9'h1FF;
    tick();
    check("t5_rd_ackA",    32'(ackA),    1);
    check("t5_rd_ramAddr", 32'(ramAddr), 32'h1FF);
    reqA = 0;
    tick(); tick();
    check("t5_validA", 32'(validA), 1);
    check("t5_doutA",  32'(doutA),  32'hC3);
    check("t5_validB", 32'(validB), 0);

    // Simultaneous reads straight out of reset
    rst = 1; tick(); rst = 0; tick();
    reqA = 1; weA = 0; addrA = 9'h010;
    reqB = 1; weB = 0; addrB = 9'h1FF;
    tick();
    check("t3_first_ackA", 32'(ackA), 1);
    check("t3_first_ackB", 32'(ackB), 0);
    reqA = 0;
    tick();
    check("t3_second_ackB", 32'(ackB), 1);
    check("t3_second_ackA", 32'(ackA), 0);
    reqB = 0;
    tick();
    check("t3_validA", 32'(validA), 1);
    check("t3_doutA",  32'(doutA),  32'h5A);
    check("t3_validB_early", 32'(validB), 0);
    tick();
    check("t3_validB", 32'(validB), 1);
    check("t3_doutB",  32'(doutB),  32'hC3);
    check("t3_validA_done", 32'(validA), 0);
    tick();

    // Both held for 8 writes each: strict A,B alternation, RAM busy every cycle
    reqA = 1; weA = 1; addrA = 9'h020; dinA = 8'hA0;
    reqB = 1; weB = 1; addrB = 9'h040; dinB = 8'hB0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check($sformatf("t4_ramEn_%0d", i), 32'(ramEn), 1);
      check($sformatf("t4_ackA_%0d", i),  32'(ackA), 32'(i % 2 == 0));
      check($sformatf("t4_ackB_%0d", i),  32'(ackB), 32'(i % 2 == 1));
      check($sformatf("t4_addr_%0d", i),  32'(ramAddr),
            (i % 2 == 0) ? 32'(9'h020 + i / 2) : 32'(9'h040 + i / 2));
      if (ackA) begin addrA = addrA + 1'b1; dinA = dinA + 1'b1; end
      if (ackB) begin addrB = addrB + 1'b1; dinB = dinB + 1'b1; end
    end
    reqA = 0; reqB = 0;
    tick();

    // A alone with a held request: at most one access every other cycle
    reqA = 1; weA = 1; addrA = 9'h060; dinA = 8'h70;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("t6_ackA_%0d", i),  32'(ackA),  32'(i % 2 == 0));
      check($sformatf("t6_ramEn_%0d", i), 32'(ramEn), 32'(i % 2 == 0));
      if (ackA) begin addrA = addrA + 1'b1; dinA = dinA + 1'b1; end
    end
    reqA = 0;
    tick();

    // Read back one word from each burst
    reqB = 1; weB = 0; addrB = 9'h063;
    tick(); reqB = 0; tick(); tick();
    check("rb_validB", 32'(validB), 1);
    check("rb_doutB",  32'(doutB),  32'h73);
    reqA = 1; weA = 0; addrA = 9'h045;
    tick(); reqA = 0; tick(); tick();
    check("rb_validA", 32'(validA), 1);
    check("rb_doutA",  32'(doutA),  32'hB5);

    // Reset mid-traffic with reads in flight
    reqA = 1; weA = 0; addrA = 9'h010;
    reqB = 1; weB = 0; addrB = 9'h1FF;
    tick(); tick();
    reqA = 0; reqB = 0;
    rst = 1;
    #1;
    check("t1_ackA",    32'(ackA),    0);
    check("t1_ackB",    32'(ackB),    0);
    check("t1_validA",  32'(validA),  0);
    check("t1_validB",  32'(validB),  0);
    check("t1_ramEn",   32'(ramEn),   0);
    check("t1_ramWe",   32'(ramWe),   0);
    check("t1_ramAddr", 32'(ramAddr), 0);
    check("t1_ramDin",  32'(ramDin),  0);
    check("t1_doutA",   32'(doutA),   0);
    check("t1_doutB",   32'(doutB),   0);
    #19;
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t1_post_validA_%0d", i), 32'(validA), 0);
      check($sformatf("t1_post_validB_%0d", i), 32'(validB), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
